trace_capture: RTL

- Parametrised sensor-trace recorder; successor to the single-window sense recorder in the CPA design.
- Captures a programmable window of encoded sensor samples into an internal buffer after a trigger (e.g. AES round strobe), with programmable trigger delay, length and decimation.
- Streams the buffer out as bytes over a valid/ready interface toward the UART transmitter.
- Sits between the sensor decoder / AES core and the top-level control FSM.

---
 rtl/trace_capture_if.sv | 9 +
 rtl/trace_capture.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/trace_capture_if.sv
// rtl/trace_capture_if.sv - byte readout stream between trace_capture and its consumer
interface trace_capture_if;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/trace_capture.sv
// rtl/trace_capture.sv - triggered sensor-trace capture buffer with byte readout
module trace_capture #(
  parameter int SAMPLE_W = 7,
  parameter int DEPTH    = 512,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int DELAY_W  = 16,
  parameter int DECIM_W  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                trigger,
  input  logic                arm,
  input  logic                abort,
  input  logic [DELAY_W-1:0]  cfg_delay,
  input  logic [ADDR_W:0]     cfg_len,
  input  logic [DECIM_W-1:0]  cfg_decim,
  input  logic                rd_start,
  trace_capture_if.master     out_bus,
  output logic                busy,
  output logic                done,
  output logic [7:0]          missed_trig
);
  localparam int LEN_W = ADDR_W + 1;
  localparam logic [LEN_W-1:0] DEPTH_LEN = LEN_W'(DEPTH);
  localparam logic [LEN_W-1:0] LEN_ONE   = LEN_W'(1);

  typedef enum logic [2:0] {IDLE, ARMED, DELAY, CAPTURE, DONE, READOUT} state_t;

  state_t              state_q;
  logic [DELAY_W-1:0]  delay_q, dly_cnt_q;
  logic [DECIM_W-1:0]  decim_q, dec_cnt_q;
  logic [LEN_W-1:0]    len_q;
  logic [ADDR_W-1:0]   waddr_q, rd_idx_q;
  logic                out_valid_q;
  logic [7:0]          missed_q;
  logic [SAMPLE_W-1:0] rdata_q;
  logic [SAMPLE_W-1:0] mem [DEPTH];

  logic [LEN_W-1:0]  len_clamped;
  logic              arm_ok, store, last_wr, last_rd, rd_en;
  logic [ADDR_W-1:0] rd_addr;

  assign len_clamped = (cfg_len > DEPTH_LEN) ? DEPTH_LEN : cfg_len;
  // rd_start takes precedence over arm when both arrive in DONE
  assign arm_ok  = arm && ((state_q == IDLE) || ((state_q == DONE) && !rd_start));
  assign last_wr = ({1'b0, waddr_q} == (len_q - LEN_ONE));
  assign last_rd = ({1'b0, rd_idx_q} == (len_q - LEN_ONE));

  always_comb begin
    store = 1'b0;
    case (state_q)
      ARMED:   store = trigger && (delay_q == '0);
      DELAY:   store = (dly_cnt_q == DELAY_W'(1));
      CAPTURE: store = (dec_cnt_q == '0);
      default: store = 1'b0;
    endcase
  end

  // Read register is refilled only when advancing, so a stalled byte stays put
  assign rd_en   = ((state_q == DONE) && rd_start && !abort) ||
                   ((state_q == READOUT) && out_valid_q && out_bus.out_ready && !last_rd);
  assign rd_addr = (state_q == READOUT) ? (rd_idx_q + ADDR_W'(1)) : '0;

  always_ff @(posedge clk) begin
    if (store && !abort && !rst) mem[waddr_q] <= sample_in;
  end

  always_ff @(posedge clk) begin
    if (rst)        rdata_q <= '0;
    else if (rd_en) rdata_q <= mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      delay_q     <= '0;
      decim_q     <= '0;
      len_q       <= '0;
      dly_cnt_q   <= '0;
      dec_cnt_q   <= '0;
      waddr_q     <= '0;
      rd_idx_q    <= '0;
      out_valid_q <= 1'b0;
      missed_q    <= '0;
    end else if (abort) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
    end else if (arm_ok) begin
      delay_q  <= cfg_delay;
      decim_q  <= cfg_decim;
      len_q    <= len_clamped;
      waddr_q  <= '0;
      missed_q <= '0;
      state_q  <= (len_clamped == '0) ? DONE : ARMED;
    end else begin
      case (state_q)
        IDLE: ;
        ARMED, DELAY, CAPTURE: begin
          if (store) begin
            waddr_q   <= waddr_q + ADDR_W'(1);
            dec_cnt_q <= decim_q;
            state_q   <= last_wr ? DONE : CAPTURE;
          end else if (state_q == ARMED) begin
            if (trigger) begin
              dly_cnt_q <= delay_q;
              state_q   <= DELAY;
            end
          end else if (state_q == DELAY) begin
            dly_cnt_q <= dly_cnt_q - DELAY_W'(1);
          end else begin
            dec_cnt_q <= dec_cnt_q - DECIM_W'(1);
          end
        end
        DONE: begin
          if (trigger && (missed_q != 8'hFF)) missed_q <= missed_q + 8'd1;
          if (rd_start) begin
            rd_idx_q    <= '0;
            out_valid_q <= (len_q != '0);
            state_q     <= READOUT;
          end
        end
        READOUT: begin
          if (!out_valid_q) begin
            state_q <= DONE;
          end else if (out_bus.out_ready) begin
            if (last_rd) begin
              out_valid_q <= 1'b0;
              state_q     <= DONE;
            end else begin
              rd_idx_q <= rd_idx_q + ADDR_W'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_bus.out_data  = 8'(rdata_q);
  assign out_bus.out_valid = out_valid_q;
  assign busy              = (state_q != IDLE) && (state_q != DONE);
  assign done              = (state_q == DONE);
  assign missed_trig       = missed_q;
endmodule
